hack_rom_loader: RTL and testbench

- Controller owning the ROM32K write port.
- Sequences HPS ioctl downloads of Hack .BIN images into instruction ROM.
- Zero-fills the unused tail of ROM after each download.
- Holds the Hack CPU in reset while ROM content is invalid, then releases it after a programmable hold period. Sits between hps_io, ROM32K and the CPU reset input.

---
 rtl/hack_pkg.sv | 10 +
 rtl/hack_reset_stretch.sv | 30 +++
 rtl/hack_rom_loader.sv | 106 ++++++++++
 tb/tb_hack_rom_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// hack_pkg: shared ROM geometry, loader state encoding and byte-swap helper
package hack_pkg;
  localparam int          ROM_AW    = 15;
  localparam int          WORD_W    = 16;
  localparam int unsigned ROM_WORDS = 32768;
  typedef enum logic [1:0] {HOLD, RUN, LOAD, FILL} loader_state_t;
  function automatic logic [WORD_W-1:0] swap16(input logic [WORD_W-1:0] w);
    return {w[7:0], w[15:8]};
  endfunction
endpackage

// File: rtl/hack_reset_stretch.sv
// hack_reset_stretch: reloadable down-counter that keeps cpu_reset high for HOLD_CYCLES counted cycles
module hack_reset_stretch
  import hack_pkg::*;
#(
  parameter int HOLD_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expire,
  output logic o_cpu_reset
);
  logic [WORD_W-1:0] r_cnt;
  logic              r_cpu_reset;
  assign o_expire    = i_dec && r_cnt <= 16'd1;
  assign o_cpu_reset = r_cpu_reset;
  // reload while ROM is being rewritten, count down while holding, release on the last count
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_cnt       <= 16'(HOLD_CYCLES);
      r_cpu_reset <= 1'b1;
    end else if (i_load) begin
      r_cnt       <= 16'(HOLD_CYCLES);
      r_cpu_reset <= 1'b1;
    end else if (i_dec && r_cnt != 16'd0) begin
      r_cnt       <= r_cnt - 16'd1;
      r_cpu_reset <= r_cnt > 16'd1;
    end
endmodule

// File: rtl/hack_rom_loader.sv
// hack_rom_loader: owns the ROM32K write port, loads HPS .BIN images, zero-fills the tail and sequences cpu_reset
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter bit SWAP_BYTES  = 1'b1,
  parameter bit FILL_EN     = 1'b1,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [WORD_W-1:0] ioctl_dout,
  output logic              ioctl_wait,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_din,
  output logic              cpu_reset,
  output logic              load_active,
  output logic [WORD_W-1:0] word_count,
  output logic              load_overflow
);
  loader_state_t     r_state, w_next;
  logic              r_rom_we, r_ioctl_wait, r_load_active, r_load_overflow;
  logic [ROM_AW-1:0] r_rom_addr, r_fill_ptr;
  logic [WORD_W-1:0] r_rom_din, r_word_count;
  logic              w_in_range, w_wr_ok, w_entry, w_busy_next, w_expire, w_fill_last, w_unused;
  logic [WORD_W-1:0] w_wr_count, w_wc_next;

  assign w_in_range  = ioctl_addr[24:16] == 9'd0;
  assign w_wr_ok     = r_state == LOAD && ioctl_wr && w_in_range;
  assign w_wr_count  = {1'b0, ioctl_addr[15:1]} + 16'd1;
  assign w_wc_next   = w_wr_ok && w_wr_count > r_word_count ? w_wr_count : r_word_count;
  assign w_fill_last = &r_fill_ptr;
  assign w_busy_next = w_next == LOAD || w_next == FILL;
  assign w_entry     = w_next == LOAD && r_state != LOAD;
  assign w_unused    = ioctl_addr[0];

  assign ioctl_wait    = r_ioctl_wait;
  assign rom_we        = r_rom_we;
  assign rom_addr      = r_rom_addr;
  assign rom_din       = r_rom_din;
  assign load_active   = r_load_active;
  assign word_count    = r_word_count;
  assign load_overflow = r_load_overflow;

  hack_reset_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_stretch (
    .i_clk       (clk_sys),
    .i_rst       (reset),
    .i_load      (w_busy_next),
    .i_dec       (r_state == HOLD),
    .o_expire    (w_expire),
    .o_cpu_reset (cpu_reset)
  );

  // state register
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) r_state <= HOLD;
    else r_state <= w_next;

  // next state: a download always wins, fill runs to the last word before honouring it
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HOLD:    w_next = ioctl_download ? LOAD : w_expire ? RUN : HOLD;
      RUN:     w_next = ioctl_download ? LOAD : RUN;
      LOAD:    w_next = ioctl_download ? LOAD : (FILL_EN && w_wc_next < 16'(ROM_WORDS)) ? FILL : HOLD;
      FILL:    w_next = !w_fill_last ? FILL : ioctl_download ? LOAD : HOLD;
      default: w_next = HOLD;
    endcase
  end

  // ROM write port: host words one cycle after the strobe in LOAD, zeros from the fill pointer in FILL
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_rom_we   <= 1'b0;
      r_rom_addr <= '0;
      r_rom_din  <= '0;
    end else begin
      r_rom_we <= w_wr_ok || r_state == FILL;
      if (w_wr_ok) begin
        r_rom_addr <= ioctl_addr[15:1];
        r_rom_din  <= SWAP_BYTES ? swap16(ioctl_dout) : ioctl_dout;
      end else if (r_state == FILL) begin
        r_rom_addr <= r_fill_ptr;
        r_rom_din  <= '0;
      end
    end

  // status: word count, sticky overflow, fill pointer and stall request
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      r_ioctl_wait    <= 1'b0;
      r_load_active   <= 1'b0;
      r_word_count    <= '0;
      r_load_overflow <= 1'b0;
      r_fill_ptr      <= '0;
    end else begin
      r_ioctl_wait    <= w_next == FILL && ioctl_download;
      r_load_active   <= w_busy_next;
      r_word_count    <= w_entry ? '0 : w_wc_next;
      r_load_overflow <= w_entry ? 1'b0 : r_load_overflow | (r_state == LOAD && ioctl_wr && !w_in_range);
      r_fill_ptr      <= r_state == FILL ? r_fill_ptr + 15'd1 : w_wc_next[ROM_AW-1:0];
    end
endmodule

// File: tb/tb_hack_rom_loader.sv
// tb_hack_rom_loader: randomized self-checking bench with a behavioural ROM image model
module tb_hack_rom_loader;
  localparam int HOLD = 16;
  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait, rom_we, cpu_reset, load_active, load_overflow;
  logic [14:0] rom_addr;
  logic [15:0] rom_din, word_count;
  int          n_tests = 0;
  int          n_fail = 0;
  int          we_cnt = 0;
  logic [15:0] exp_rom [0:32767];
  logic [15:0] dut_rom [0:32767];

  always #5 clk_sys = ~clk_sys;

  hack_rom_loader #(.SWAP_BYTES(1'b1), .FILL_EN(1'b1), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .rom_we(rom_we),
    .rom_addr(rom_addr), .rom_din(rom_din), .cpu_reset(cpu_reset), .load_active(load_active),
    .word_count(word_count), .load_overflow(load_overflow)
  );

  always @(posedge clk_sys)
    if (rom_we === 1'b1) begin
      dut_rom[rom_addr] <= rom_din;
      we_cnt <= we_cnt + 1;
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t exceeded limit 2000000", $time);
    $fatal(1);
  end

  function automatic logic [15:0] sw(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic wait_release(output int n);
    n = -1;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      if (cpu_reset === 1'b0) begin
        n = c;
        return;
      end
    end
  endtask

  task automatic run_fill(input int first, input int stop, input logic exp_wait,
                          output int nw, output int nb, output logic to);
    int   exp_a;
    logic started;
    nw = 0; nb = 0; to = 1'b1; started = 1'b0; exp_a = first;
    for (int c = 0; c < 40000; c++) begin
      tick();
      if (rom_we === 1'b1) begin
        if (int'(rom_addr) != exp_a || rom_din !== 16'h0) nb++;
        exp_a = int'(rom_addr) + 1;
        started = 1'b1;
        nw++;
      end else if (started) nb++;
      if (!(rom_we === 1'b1 && int'(rom_addr) == 32767) && (ioctl_wait !== exp_wait || cpu_reset !== 1'b1)) nb++;
      if (rom_we === 1'b1 && int'(rom_addr) == stop) begin
        to = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if ({cpu_reset, rom_we, ioctl_wait, load_active, load_overflow} !== 5'b10000 || rom_addr !== 15'd0 || rom_din !== 16'd0 || word_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: cpu_reset=%b rom_we=%b wait=%b active=%b ovf=%b addr=%0h din=%0h wc=%0d, required 1 0 0 0 0 0 0 0",
               cpu_reset, rom_we, ioctl_wait, load_active, load_overflow, rom_addr, rom_din, word_count);
    end
    reset = 1'b0;
    wait_release(n);
    n_tests++;
    if (n != HOLD) begin n_fail++; $display("FAIL reset_hold: released after %0d cycles, required %0d", n, HOLD); end
    n_tests++;
    if (we_cnt != 0) begin n_fail++; $display("FAIL reset_no_write: %0d rom writes, required 0", we_cnt); end
    repeat (5) tick();
    n_tests++;
    if (cpu_reset !== 1'b0 || load_active !== 1'b0) begin
      n_fail++; $display("FAIL run_idle: cpu_reset=%b active=%b, required 0 0", cpu_reset, load_active);
    end
  endtask

  task automatic test_download_fill();
    logic [15:0] d [4];
    int nw, nb, n, c0;
    logic to;
    d = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    ioctl_download = 1'b1;
    #1;
    n_tests++;
    if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL run_to_load_latency: cpu_reset=%b before edge, required 0", cpu_reset); end
    tick();
    n_tests++;
    if (cpu_reset !== 1'b1 || load_active !== 1'b1 || word_count !== 16'd0) begin
      n_fail++; $display("FAIL load_entry: cpu_reset=%b active=%b wc=%0d, required 1 1 0", cpu_reset, load_active, word_count);
    end
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(2 * i); ioctl_dout = d[i];
      tick();
      n_tests++;
      if (rom_we !== 1'b1 || rom_addr !== 15'(i) || rom_din !== sw(d[i])) begin
        n_fail++; $display("FAIL load_write%0d: we=%b addr=%0d din=%h, required 1 %0d %h", i, rom_we, rom_addr, rom_din, i, sw(d[i]));
      end
      exp_rom[i] = sw(d[i]);
    end
    ioctl_wr = 1'b0;
    tick();
    n_tests++;
    if (rom_we !== 1'b0 || word_count !== 16'd4) begin
      n_fail++; $display("FAIL load_count: we=%b wc=%0d, required 0 4", rom_we, word_count);
    end
    ioctl_download = 1'b0;
    run_fill(4, 32767, 1'b0, nw, nb, to);
    for (int i = 4; i < 32768; i++) exp_rom[i] = 16'h0;
    n_tests++;
    if (to || nw != 32764 || nb != 0) begin
      n_fail++; $display("FAIL fill_tail: timeout=%b writes=%0d bad=%0d, required 0 32764 0", to, nw, nb);
    end
    n_tests++;
    if (cpu_reset !== 1'b1 || load_active !== 1'b0) begin
      n_fail++; $display("FAIL fill_end: cpu_reset=%b active=%b, required 1 0", cpu_reset, load_active);
    end
    c0 = we_cnt;
    wait_release(n);
    n_tests++;
    if (n != HOLD || we_cnt != c0 + 1) begin
      n_fail++; $display("FAIL fill_hold: released after %0d writes %0d, required %0d 1", n, we_cnt - c0, HOLD);
    end
  endtask

  task automatic test_overflow_interrupt();
    int wc, k, ovf_pos, idx, nw, nb;
    logic to;
    logic [15:0] v;
    ioctl_download = 1'b1;
    tick();
    wc = 0;
    k = $urandom_range(3, 8);
    ovf_pos = $urandom_range(0, k - 1);
    for (int i = 0; i < k; i++) begin
      if (i == ovf_pos) begin
        ioctl_wr = 1'b1; ioctl_addr = {9'($urandom_range(1, 511)), 16'($urandom)}; ioctl_dout = 16'($urandom);
        tick();
        n_tests++;
        if (rom_we !== 1'b0) begin n_fail++; $display("FAIL ovf_suppress: we=%b addr=%h, required 0", rom_we, ioctl_addr); end
      end
      idx = $urandom_range(0, 90);
      v = 16'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = {9'd0, 15'(idx), 1'($urandom)}; ioctl_dout = v;
      tick();
      n_tests++;
      if (rom_we !== 1'b1 || rom_addr !== 15'(idx) || rom_din !== sw(v)) begin
        n_fail++; $display("FAIL rand_write%0d: we=%b addr=%0d din=%h, required 1 %0d %h", i, rom_we, rom_addr, rom_din, idx, sw(v));
      end
      exp_rom[idx] = sw(v);
      if (idx + 1 > wc) wc = idx + 1;
      ioctl_wr = 1'b0;
      if ($urandom_range(0, 1) == 1) tick();
    end
    ioctl_wr = 1'b0;
    tick();
    n_tests++;
    if (load_overflow !== 1'b1 || word_count !== 16'(wc)) begin
      n_fail++; $display("FAIL ovf_flag: ovf=%b wc=%0d, required 1 %0d", load_overflow, word_count, wc);
    end
    ioctl_download = 1'b0;
    run_fill(wc, 100, 1'b0, nw, nb, to);
    for (int i = wc; i <= 100; i++) exp_rom[i] = 16'h0;
    n_tests++;
    if (to || nw != 101 - wc || nb != 0) begin
      n_fail++; $display("FAIL fill_to_100: timeout=%b writes=%0d bad=%0d, required 0 %0d 0", to, nw, nb, 101 - wc);
    end
    ioctl_download = 1'b1;
    run_fill(101, 32767, 1'b1, nw, nb, to);
    for (int i = 101; i < 32768; i++) exp_rom[i] = 16'h0;
    n_tests++;
    if (to || nw != 32667 || nb != 0) begin
      n_fail++; $display("FAIL fill_wait: timeout=%b writes=%0d bad=%0d, required 0 32667 0", to, nw, nb);
    end
    n_tests++;
    if (ioctl_wait !== 1'b0 || load_active !== 1'b1 || cpu_reset !== 1'b1 || load_overflow !== 1'b0 || word_count !== 16'd0) begin
      n_fail++; $display("FAIL fill_to_load: wait=%b active=%b cpu_reset=%b ovf=%b wc=%0d, required 0 1 1 0 0",
                         ioctl_wait, load_active, cpu_reset, load_overflow, word_count);
    end
  endtask

  task automatic test_full_image();
    int k, idx, n, c0;
    logic [15:0] v;
    tick();
    n_tests++;
    if (rom_we !== 1'b0 || ioctl_wait !== 1'b0 || load_active !== 1'b1) begin
      n_fail++; $display("FAIL load_after_fill: we=%b wait=%b active=%b, required 0 0 1", rom_we, ioctl_wait, load_active);
    end
    k = $urandom_range(2, 6);
    for (int i = 0; i < k; i++) begin
      idx = $urandom_range(0, 32766);
      v = 16'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = {9'd0, 15'(idx), 1'($urandom)}; ioctl_dout = v;
      tick();
      n_tests++;
      if (rom_we !== 1'b1 || rom_addr !== 15'(idx) || rom_din !== sw(v)) begin
        n_fail++; $display("FAIL b2b_write%0d: we=%b addr=%0d din=%h, required 1 %0d %h", i, rom_we, rom_addr, rom_din, idx, sw(v));
      end
      exp_rom[idx] = sw(v);
    end
    v = 16'($urandom);
    ioctl_addr = {9'd0, 15'h7FFF, 1'($urandom)}; ioctl_dout = v; ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    exp_rom[32767] = sw(v);
    n_tests++;
    if (rom_we !== 1'b1 || rom_addr !== 15'h7FFF || rom_din !== sw(v)) begin
      n_fail++; $display("FAIL coincident_write: we=%b addr=%0d din=%h, required 1 32767 %h", rom_we, rom_addr, rom_din, sw(v));
    end
    n_tests++;
    if (load_active !== 1'b0 || word_count !== 16'd32768 || cpu_reset !== 1'b1) begin
      n_fail++; $display("FAIL full_skip_fill: active=%b wc=%0d cpu_reset=%b, required 0 32768 1", load_active, word_count, cpu_reset);
    end
    c0 = we_cnt;
    wait_release(n);
    n_tests++;
    if (n != HOLD || we_cnt != c0 + 1) begin
      n_fail++; $display("FAIL full_hold: released after %0d writes %0d, required %0d 1", n, we_cnt - c0, HOLD);
    end
  endtask

  task automatic test_rom_image(input string tag);
    int bad, first;
    bad = 0; first = -1;
    for (int i = 0; i < 32768; i++)
      if (dut_rom[i] !== exp_rom[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL rom_image_%s: %0d words differ, first at %0d got %h, required 0 differing (%h)",
               tag, bad, first, dut_rom[first], exp_rom[first]);
    end
  endtask

  task automatic test_reset_mid_fill();
    int wc, k, idx, nw, nb, n, c0;
    logic to;
    logic [15:0] v;
    ioctl_download = 1'b1;
    tick();
    wc = 0;
    k = $urandom_range(1, 3);
    for (int i = 0; i < k; i++) begin
      idx = $urandom_range(0, 49);
      v = 16'($urandom);
      ioctl_wr = 1'b1; ioctl_addr = {9'd0, 15'(idx), 1'b0}; ioctl_dout = v;
      tick();
      exp_rom[idx] = sw(v);
      if (idx + 1 > wc) wc = idx + 1;
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    run_fill(wc, 200, 1'b0, nw, nb, to);
    for (int i = wc; i < 200; i++) exp_rom[i] = 16'h0;
    n_tests++;
    if (to || nw != 201 - wc || nb != 0) begin
      n_fail++; $display("FAIL fill_to_200: timeout=%b writes=%0d bad=%0d, required 0 %0d 0", to, nw, nb, 201 - wc);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (rom_we !== 1'b0 || load_active !== 1'b0 || cpu_reset !== 1'b1 || word_count !== 16'd0 || ioctl_wait !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort: we=%b active=%b cpu_reset=%b wc=%0d wait=%b, required 0 0 1 0 0",
                         rom_we, load_active, cpu_reset, word_count, ioctl_wait);
    end
    c0 = we_cnt;
    tick();
    reset = 1'b0;
    wait_release(n);
    n_tests++;
    if (n != HOLD || we_cnt != c0) begin
      n_fail++; $display("FAIL abort_hold: released after %0d writes %0d, required %0d 0", n, we_cnt - c0, HOLD);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      exp_rom[i] = 16'(i * 7 + 3);
      dut_rom[i] = 16'(i * 7 + 3);
    end
    test_reset();
    test_download_fill();
    test_rom_image("fill");
    test_overflow_interrupt();
    test_full_image();
    test_rom_image("full");
    test_reset_mid_fill();
    test_rom_image("abort");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
